csr_regblock: RTL and testbench
===============================

Name: csr_regblock

Overview:
- Memory-mapped control/status register block with four 32-bit registers.
- Sits between a simple request/ack CPU interface and the hardware logic.
- Exposes decoded register fields to the hardware on a packed output struct (hwif_out) and samples hardware status and events from a packed input struct (hwif_in).
- hwif_out must never carry X/Z after reset is released.

Parameters:
- ADDR_W, 4, byte-address width; 4 words, word-aligned.
- DATA_W, 32, CPU data width; fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- cpuif_req  in  1  single-cycle transfer request.
- cpuif_req_is_wr  in  1  1 = write, 0 = read.
- cpuif_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpuif_wr_data  in  32  write data.
- cpuif_wr_biten  in  32  per-bit write enable.
- cpuif_rd_ack  out  1  read response valid.
- cpuif_rd_err  out  1  read error.
- cpuif_rd_data  out  32  read data.
- cpuif_wr_ack  out  1  write response.
- cpuif_wr_err  out  1  write error.
- hwif_in  in  10  {status[7:0], event_pulse, incr}.
- hwif_out  out  27  {enable, threshold[7:0], irq, count[15:0], count_hit}.

Behaviour:
- Reset is synchronous on rst == 0:
  - all acks/errs 0, rd_data 0;
  - CTRL.enable = 0, CTRL.threshold = 0x10, EVENT = 0, COUNT = 0.
- Transaction timing:
  - No stall; a new request is accepted every cycle.
  - rd_ack/wr_ack pulse exactly 1 cycle after req, with err and data registered alongside the ack.
  - rd_data is 0 whenever rd_ack is 0.
- Register map:
  - 0x0 CTRL, RW: [0] enable, [15:8] threshold. Other bits read 0.
  - 0x4 STATUS, RO: [7:0] = hwif_in.status sampled at request. Writes are acked with no error and no effect.
  - 0x8 EVENT, W1C: [0] sticky, set when hwif_in.event_pulse is high. Write 1 (with biten) clears.
  - 0xC COUNT, RW: [15:0]. Increments by 1 per cycle when hwif_in.incr && enable. Wraps 0xFFFF -> 0x0000.
- Writes apply only bits with biten = 1; the register updates on the cycle the ack is produced.
- Unmapped address: none for ADDR_W = 4. If ADDR_W is enlarged, any address >= 0x10 returns err = 1 and rd_data = 0, and the write is dropped.
- Simultaneous events:
  - EVENT hardware set and W1C in the same cycle: set wins (bit = 1).
  - COUNT software write and increment in the same cycle: the write wins, with no increment that cycle.
- Outputs:
  - hwif_out.irq = EVENT[0] & enable (combinational from registers).
  - hwif_out.count_hit = (count >= {8'h0, threshold}), unsigned.
  - enable, threshold and count are driven directly from their flops.
- Reset asserted mid-transaction: the pending ack is dropped and registers return to reset values.

Optional Feature:
- Macro PARITY_CHECK_EN.
- When defined:
  - An extra output port parity_error (1 bit) is added.
  - Each software-writable register (CTRL, EVENT, COUNT) stores an even-parity bit over its stored fields, recomputed on every software or hardware update.
  - parity_error is registered: 1 the cycle after any stored parity mismatches its recomputed value, else 0. It resets to 0 and is never X after reset.
- When undefined: the port and parity flops are absent, and behaviour is otherwise identical.

Decomposition:
- Package csr_regblock_pkg holds:
  - typedef csr_regblock__in_t and csr_regblock__out_t (packed structs above);
  - address localparams ADDR_CTRL/STATUS/EVENT/COUNT;
  - reset-value localparams.
- One sub-module is natural: csr_regblock_cpuif, which performs request decode and ack/err/rdata registration.
- Field storage stays in the top module.

Test Plan:
- Reset check: hold rst = 0 for 5 cycles, then release. Read 0x0 -> 0x00001000; read 0xC -> 0. hwif_out has no X; enable = 0, irq = 0.
- Biten masking: write 0x0 data 0x0000_2001 with biten 0xFFFF_FFFF -> enable = 1, threshold = 0x20. Then write data 0 with biten 0x0000_FF00 -> threshold = 0, enable stays 1. Ack arrives 1 cycle after req, err = 0.
- Status read: hwif_in.status = 0xA5 -> read 0x4 returns 0x000000A5. Write 0x4 -> wr_ack = 1, err = 0, value unchanged.
- W1C collision: pulse event_pulse -> EVENT = 1 and irq = 1 (enable = 1). Write 0x8 with 1 -> clears. Repeat with event_pulse in the same cycle as the clear -> stays 1.
- Counter wrap and priority:
  - write COUNT = 0xFFFE, hold incr for 3 cycles -> 0xFFFF, 0x0000, 0x0001;
  - count_hit toggles against threshold 0x10;
  - write and incr in the same cycle -> the written value results.
- With PARITY_CHECK_EN: run all the above -> parity_error stays 0 throughout.

Source files
------------

// File: rtl/csr_regblock_pkg.sv
// csr_regblock_pkg: hardware interface structs, register addresses,
// reset values and a parity helper shared by the register block.
package csr_regblock_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic       event_pulse;
    logic       incr;
  } csr_regblock__in_t;

  typedef struct packed {
    logic        enable;
    logic [7:0]  threshold;
    logic        irq;
    logic [15:0] count;
    logic        count_hit;
  } csr_regblock__out_t;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_EVENT  = 4'h8;
  localparam logic [3:0] ADDR_COUNT  = 4'hC;

  localparam logic        CTRL_ENABLE_RST    = 1'b0;
  localparam logic [7:0]  CTRL_THRESHOLD_RST = 8'h10;
  localparam logic        EVENT_STICKY_RST   = 1'b0;
  localparam logic [15:0] COUNT_RST          = 16'h0000;

  // Even-parity bit: makes the total number of ones (data + bit) even.
  function automatic logic evenParity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/csr_regblock_cpuif.sv
// csr_regblock_cpuif: decodes CPU requests into per-register write strobes
// and registers the read/write responses one cycle after each request.
module csr_regblock_cpuif
  import csr_regblock_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuif_req,
  input  logic              cpuif_req_is_wr,
  input  logic [ADDR_W-1:0] cpuif_addr,
  input  logic [DATA_W-1:0] i_ctrlWord,
  input  logic [DATA_W-1:0] i_statusWord,
  input  logic [DATA_W-1:0] i_eventWord,
  input  logic [DATA_W-1:0] i_countWord,
  output logic              o_wrCtrl,
  output logic              o_wrEvent,
  output logic              o_wrCount,
  output logic              cpuif_rd_ack,
  output logic              cpuif_rd_err,
  output logic [DATA_W-1:0] cpuif_rd_data,
  output logic              cpuif_wr_ack,
  output logic              cpuif_wr_err
);

  logic              w_inRange;
  logic [3:0]        w_wordAddr;
  logic [DATA_W-1:0] w_rdWord;
  logic              w_isRd;
  logic              w_isWr;
  logic              w_unusedAddrLow;

  // Only a wider address bus can point outside the four-word map.
  generate
    if (ADDR_W > 4) begin : g_wideAddr
      assign w_inRange = (cpuif_addr[ADDR_W-1:4] == '0);
    end else begin : g_narrowAddr
      assign w_inRange = 1'b1;
    end
  endgenerate

  assign w_wordAddr      = {cpuif_addr[3:2], 2'b00};
  assign w_unusedAddrLow = ^cpuif_addr[1:0];
  assign w_isRd          = cpuif_req & ~cpuif_req_is_wr;
  assign w_isWr          = cpuif_req & cpuif_req_is_wr;

  assign o_wrCtrl  = w_isWr & w_inRange & (w_wordAddr == ADDR_CTRL);
  assign o_wrEvent = w_isWr & w_inRange & (w_wordAddr == ADDR_EVENT);
  assign o_wrCount = w_isWr & w_inRange & (w_wordAddr == ADDR_COUNT);

  // Select the register image addressed by the current request.
  always_comb begin
    w_rdWord = '0;
    case (w_wordAddr)
      ADDR_CTRL:   w_rdWord = i_ctrlWord;
      ADDR_STATUS: w_rdWord = i_statusWord;
      ADDR_EVENT:  w_rdWord = i_eventWord;
      ADDR_COUNT:  w_rdWord = i_countWord;
      default:     w_rdWord = '0;
    endcase
    if (!w_inRange) begin
      w_rdWord = '0;
    end
  end

  // Register ack, error and read data together one cycle after the request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpuif_rd_ack  <= 1'b0;
      cpuif_rd_err  <= 1'b0;
      cpuif_rd_data <= '0;
      cpuif_wr_ack  <= 1'b0;
      cpuif_wr_err  <= 1'b0;
    end else begin
      cpuif_rd_ack  <= w_isRd;
      cpuif_rd_err  <= w_isRd & ~w_inRange;
      cpuif_rd_data <= w_isRd ? w_rdWord : '0;
      cpuif_wr_ack  <= w_isWr;
      cpuif_wr_err  <= w_isWr & ~w_inRange;
    end
  end

endmodule

// File: rtl/csr_regblock.sv
// csr_regblock: four-register CSR block (CTRL, STATUS, EVENT, COUNT) with
// field storage and hardware-side outputs. Define PARITY_CHECK_EN to add
// per-register parity storage and a registered parity_error output.
module csr_regblock
  import csr_regblock_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpuif_req,
  input  logic               cpuif_req_is_wr,
  input  logic [ADDR_W-1:0]  cpuif_addr,
  input  logic [DATA_W-1:0]  cpuif_wr_data,
  input  logic [DATA_W-1:0]  cpuif_wr_biten,
  output logic               cpuif_rd_ack,
  output logic               cpuif_rd_err,
  output logic [DATA_W-1:0]  cpuif_rd_data,
  output logic               cpuif_wr_ack,
  output logic               cpuif_wr_err,
  input  csr_regblock__in_t  hwif_in,
  output csr_regblock__out_t hwif_out
`ifdef PARITY_CHECK_EN
  ,
  output logic               parity_error
`endif
);

  logic        r_enable;
  logic [7:0]  r_threshold;
  logic        r_event;
  logic [15:0] r_count;

  logic        w_enableNext;
  logic [7:0]  w_thresholdNext;
  logic        w_eventNext;
  logic [15:0] w_countNext;

  logic        w_wrCtrl;
  logic        w_wrEvent;
  logic        w_wrCount;
  logic        w_unusedWrHigh;

  logic [DATA_W-1:0] w_ctrlWord;
  logic [DATA_W-1:0] w_statusWord;
  logic [DATA_W-1:0] w_eventWord;
  logic [DATA_W-1:0] w_countWord;

  assign w_ctrlWord     = {16'h0000, r_threshold, 7'h00, r_enable};
  assign w_statusWord   = {24'h000000, hwif_in.status};
  assign w_eventWord    = {31'h00000000, r_event};
  assign w_countWord    = {16'h0000, r_count};
  assign w_unusedWrHigh = ^{cpuif_wr_data[31:16], cpuif_wr_biten[31:16]};

  csr_regblock_cpuif #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cpuif (
    .clk            (clk),
    .rst            (rst),
    .cpuif_req      (cpuif_req),
    .cpuif_req_is_wr(cpuif_req_is_wr),
    .cpuif_addr     (cpuif_addr),
    .i_ctrlWord     (w_ctrlWord),
    .i_statusWord   (w_statusWord),
    .i_eventWord    (w_eventWord),
    .i_countWord    (w_countWord),
    .o_wrCtrl       (w_wrCtrl),
    .o_wrEvent      (w_wrEvent),
    .o_wrCount      (w_wrCount),
    .cpuif_rd_ack   (cpuif_rd_ack),
    .cpuif_rd_err   (cpuif_rd_err),
    .cpuif_rd_data  (cpuif_rd_data),
    .cpuif_wr_ack   (cpuif_wr_ack),
    .cpuif_wr_err   (cpuif_wr_err)
  );

  // Next field values: biten-masked writes, hardware set beating W1C,
  // and a software COUNT write suppressing that cycle's increment.
  always_comb begin
    w_enableNext    = r_enable;
    w_thresholdNext = r_threshold;
    w_eventNext     = r_event;
    w_countNext     = r_count;
    if (w_wrCtrl) begin
      w_enableNext    = (r_enable & ~cpuif_wr_biten[0]) | (cpuif_wr_data[0] & cpuif_wr_biten[0]);
      w_thresholdNext = (r_threshold & ~cpuif_wr_biten[15:8]) |
                        (cpuif_wr_data[15:8] & cpuif_wr_biten[15:8]);
    end
    if (hwif_in.event_pulse) begin
      w_eventNext = 1'b1;
    end else if (w_wrEvent && cpuif_wr_biten[0] && cpuif_wr_data[0]) begin
      w_eventNext = 1'b0;
    end
    if (w_wrCount) begin
      w_countNext = (r_count & ~cpuif_wr_biten[15:0]) |
                    (cpuif_wr_data[15:0] & cpuif_wr_biten[15:0]);
    end else if (hwif_in.incr && r_enable) begin
      w_countNext = r_count + 16'd1;
    end
  end

  // Field storage, loaded on the same edge that produces the CPU ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_enable    <= CTRL_ENABLE_RST;
      r_threshold <= CTRL_THRESHOLD_RST;
      r_event     <= EVENT_STICKY_RST;
      r_count     <= COUNT_RST;
    end else begin
      r_enable    <= w_enableNext;
      r_threshold <= w_thresholdNext;
      r_event     <= w_eventNext;
      r_count     <= w_countNext;
    end
  end

  assign hwif_out.enable    = r_enable;
  assign hwif_out.threshold = r_threshold;
  assign hwif_out.irq       = r_event & r_enable;
  assign hwif_out.count     = r_count;
  assign hwif_out.count_hit = (r_count >= {8'h00, r_threshold});

`ifdef PARITY_CHECK_EN
  logic r_ctrlPar;
  logic r_eventPar;
  logic r_countPar;
  logic r_parityError;

  // Keep a parity bit beside each writable register and flag any disagreement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrlPar     <= evenParity({23'h0, CTRL_ENABLE_RST, CTRL_THRESHOLD_RST});
      r_eventPar    <= evenParity({31'h0, EVENT_STICKY_RST});
      r_countPar    <= evenParity({16'h0, COUNT_RST});
      r_parityError <= 1'b0;
    end else begin
      r_ctrlPar     <= evenParity({23'h0, w_enableNext, w_thresholdNext});
      r_eventPar    <= evenParity({31'h0, w_eventNext});
      r_countPar    <= evenParity({16'h0, w_countNext});
      r_parityError <= (r_ctrlPar  != evenParity({23'h0, r_enable, r_threshold})) |
                       (r_eventPar != evenParity({31'h0, r_event})) |
                       (r_countPar != evenParity({16'h0, r_count}));
    end
  end

  assign parity_error = r_parityError;
`endif

endmodule

// File: tb/tb_csr_regblock.sv
// tb_csr_regblock: directed stimulus for csr_regblock with a word-level
// register model checked against the DUT on every cycle, plus literal checks.
module tb_csr_regblock;
  import csr_regblock_pkg::*;

  localparam logic [31:0] CTRL_RW_MASK = 32'h0000_FF01;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpuif_req;
  logic               cpuif_req_is_wr;
  logic [3:0]         cpuif_addr;
  logic [31:0]        cpuif_wr_data;
  logic [31:0]        cpuif_wr_biten;
  logic               cpuif_rd_ack;
  logic               cpuif_rd_err;
  logic [31:0]        cpuif_rd_data;
  logic               cpuif_wr_ack;
  logic               cpuif_wr_err;
  csr_regblock__in_t  hwif_in;
  csr_regblock__out_t hwif_out;
`ifdef PARITY_CHECK_EN
  logic               parity_error;
`endif

  int compareCount = 0;
  int failCount    = 0;

  // Word-level model state and expected response
  logic [31:0] mCtrl;
  logic        mEvent;
  logic [15:0] mCount;
  logic        expRdAck;
  logic        expWrAck;
  logic [31:0] expRdData;
  bit          modelValid = 1'b0;

  csr_regblock #(
    .ADDR_W(4),
    .DATA_W(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpuif_req      (cpuif_req),
    .cpuif_req_is_wr(cpuif_req_is_wr),
    .cpuif_addr     (cpuif_addr),
    .cpuif_wr_data  (cpuif_wr_data),
    .cpuif_wr_biten (cpuif_wr_biten),
    .cpuif_rd_ack   (cpuif_rd_ack),
    .cpuif_rd_err   (cpuif_rd_err),
    .cpuif_rd_data  (cpuif_rd_data),
    .cpuif_wr_ack   (cpuif_wr_ack),
    .cpuif_wr_err   (cpuif_wr_err),
    .hwif_in        (hwif_in),
    .hwif_out       (hwif_out)
`ifdef PARITY_CHECK_EN
    ,
    .parity_error   (parity_error)
`endif
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic isWr, input logic [3:0] addr,
                               input logic [31:0] data, input logic [31:0] biten,
                               input logic pulse, input logic incr);
    @(posedge clk);
    #1;
    cpuif_req           = req;
    cpuif_req_is_wr     = isWr;
    cpuif_addr          = addr;
    cpuif_wr_data       = data;
    cpuif_wr_biten      = biten;
    hwif_in.event_pulse = pulse;
    hwif_in.incr        = incr;
  endtask

  task automatic cpuRead(input logic [3:0] addr, input logic [31:0] expected, input string name);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, " rd_ack"}, {31'h0, cpuif_rd_ack}, 32'h1);
    checkOutput({name, " rd_data"}, cpuif_rd_data, expected);
  endtask

  task automatic cpuWrite(input logic [3:0] addr, input logic [31:0] data, input logic [31:0] biten,
                          input string name);
    applyStimulus(1'b1, 1'b1, addr, data, biten, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, " wr_ack"}, {31'h0, cpuif_wr_ack}, 32'h1);
    checkOutput({name, " wr_err"}, {31'h0, cpuif_wr_err}, 32'h0);
  endtask

  // Expected hardware-side view derived from the model's register words
  function automatic logic [26:0] modelHwif();
    logic       en;
    logic [7:0] thr;
    logic       hit;
    en  = mCtrl[0];
    thr = mCtrl[15:8];
    hit = (int'(mCount) >= int'(thr));
    return {en, thr, en & mEvent, mCount, hit};
  endfunction

  // Advance the register model on each rising edge from the sampled inputs
  always @(posedge clk) begin
    logic oldEnable;
    int   wordIdx;
    if (rst === 1'b0) begin
      mCtrl      = 32'h0000_1000;
      mEvent     = 1'b0;
      mCount     = 16'h0000;
      expRdAck   = 1'b0;
      expWrAck   = 1'b0;
      expRdData  = 32'h0;
      modelValid = 1'b1;
    end else begin
      oldEnable = mCtrl[0];
      wordIdx   = int'(cpuif_addr) / 4;
      expRdAck  = cpuif_req && !cpuif_req_is_wr;
      expWrAck  = cpuif_req && cpuif_req_is_wr;
      expRdData = 32'h0;
      if (expRdAck) begin
        case (wordIdx)
          0:       expRdData = mCtrl;
          1:       expRdData = {24'h0, hwif_in.status};
          2:       expRdData = {31'h0, mEvent};
          default: expRdData = {16'h0, mCount};
        endcase
      end
      if (hwif_in.event_pulse) begin
        mEvent = 1'b1;
      end else if (expWrAck && wordIdx == 2 && (cpuif_wr_data[0] & cpuif_wr_biten[0])) begin
        mEvent = 1'b0;
      end
      if (expWrAck && wordIdx == 3) begin
        mCount = 16'((32'(mCount) & ~cpuif_wr_biten) | (cpuif_wr_data & cpuif_wr_biten));
      end else if (hwif_in.incr && oldEnable) begin
        mCount = 16'((int'(mCount) + 1) % 65536);
      end
      if (expWrAck && wordIdx == 0) begin
        mCtrl = ((mCtrl & ~cpuif_wr_biten) | (cpuif_wr_data & cpuif_wr_biten)) & CTRL_RW_MASK;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cyc rd_ack", {31'h0, cpuif_rd_ack}, {31'h0, expRdAck});
      checkOutput("cyc rd_err", {31'h0, cpuif_rd_err}, 32'h0);
      checkOutput("cyc rd_data", cpuif_rd_data, expRdData);
      checkOutput("cyc wr_ack", {31'h0, cpuif_wr_ack}, {31'h0, expWrAck});
      checkOutput("cyc wr_err", {31'h0, cpuif_wr_err}, 32'h0);
      checkOutput("cyc hwif_out", {5'h0, hwif_out}, {5'h0, modelHwif()});
`ifdef PARITY_CHECK_EN
      checkOutput("cyc parity_error", {31'h0, parity_error}, 32'h0);
`endif
    end
  end

  // Abort a run that stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations
  initial begin
    rst             = 1'b0;
    cpuif_req       = 1'b0;
    cpuif_req_is_wr = 1'b0;
    cpuif_addr      = 4'h0;
    cpuif_wr_data   = 32'h0;
    cpuif_wr_biten  = 32'h0;
    hwif_in         = '0;

    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset hwif_out", {5'h0, hwif_out}, 32'h0040_0000);
    checkOutput("reset enable", {31'h0, hwif_out.enable}, 32'h0);
    checkOutput("reset irq", {31'h0, hwif_out.irq}, 32'h0);
    cpuRead(ADDR_CTRL, 32'h0000_1000, "reset CTRL");
    cpuRead(ADDR_COUNT, 32'h0000_0000, "reset COUNT");

    $display("[TB] biten masking");
    cpuWrite(ADDR_CTRL, 32'h0000_2001, 32'hFFFF_FFFF, "ctrl full");
    checkOutput("ctrl full hwif_out", {5'h0, hwif_out}, 32'h0480_0000);
    cpuWrite(ADDR_CTRL, 32'h0000_0000, 32'h0000_FF00, "ctrl thr");
    checkOutput("ctrl thr enable", {31'h0, hwif_out.enable}, 32'h1);
    checkOutput("ctrl thr threshold", {24'h0, hwif_out.threshold}, 32'h0);
    checkOutput("ctrl thr hwif_out", {5'h0, hwif_out}, 32'h0400_0001);
    cpuWrite(ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_00FE, "ctrl no-op");
    cpuRead(ADDR_CTRL, 32'h0000_0001, "ctrl readback");

    $display("[TB] status read");
    hwif_in.status = 8'hA5;
    cpuRead(ADDR_STATUS, 32'h0000_00A5, "status");
    cpuWrite(ADDR_STATUS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "status wr");
    cpuRead(ADDR_STATUS, 32'h0000_00A5, "status after wr");

    $display("[TB] event W1C");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("event set irq", {31'h0, hwif_out.irq}, 32'h1);
    cpuRead(ADDR_EVENT, 32'h0000_0001, "event set");
    cpuWrite(ADDR_EVENT, 32'h0000_0001, 32'h0000_0001, "event clr");
    checkOutput("event clr irq", {31'h0, hwif_out.irq}, 32'h0);
    applyStimulus(1'b1, 1'b1, ADDR_EVENT, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("collide wr_ack", {31'h0, cpuif_wr_ack}, 32'h1);
    checkOutput("collide irq", {31'h0, hwif_out.irq}, 32'h1);
    cpuRead(ADDR_EVENT, 32'h0000_0001, "collide event");
    cpuWrite(ADDR_EVENT, 32'h0000_0001, 32'h0000_0000, "event no-biten");
    checkOutput("no-biten irq", {31'h0, hwif_out.irq}, 32'h1);
    cpuWrite(ADDR_EVENT, 32'h0000_0001, 32'h0000_0001, "event clr2");
    checkOutput("clr2 irq", {31'h0, hwif_out.irq}, 32'h0);

    $display("[TB] counter wrap and priority");
    cpuWrite(ADDR_CTRL, 32'h0000_1001, 32'hFFFF_FFFF, "ctrl thr16");
    cpuWrite(ADDR_COUNT, 32'h0000_FFFE, 32'hFFFF_FFFF, "count fffe");
    checkOutput("count fffe", {16'h0, hwif_out.count}, 32'h0000_FFFE);
    checkOutput("count fffe hit", {31'h0, hwif_out.count_hit}, 32'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("count ffff", {16'h0, hwif_out.count}, 32'h0000_FFFF);
    checkOutput("count ffff hit", {31'h0, hwif_out.count_hit}, 32'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("count wrap", {16'h0, hwif_out.count}, 32'h0000_0000);
    checkOutput("count wrap hit", {31'h0, hwif_out.count_hit}, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("count 0001", {16'h0, hwif_out.count}, 32'h0000_0001);
    checkOutput("count 0001 hit", {31'h0, hwif_out.count_hit}, 32'h0);
    cpuRead(ADDR_COUNT, 32'h0000_0001, "count read");

    applyStimulus(1'b1, 1'b1, ADDR_COUNT, 32'h0000_000F, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wr+incr wr_ack", {31'h0, cpuif_wr_ack}, 32'h1);
    checkOutput("wr+incr count", {16'h0, hwif_out.count}, 32'h0000_000F);
    checkOutput("wr+incr hit", {31'h0, hwif_out.count_hit}, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("count 0010", {16'h0, hwif_out.count}, 32'h0000_0010);
    checkOutput("count 0010 hit", {31'h0, hwif_out.count_hit}, 32'h1);

    cpuWrite(ADDR_CTRL, 32'h0000_1000, 32'h0000_0001, "ctrl disable");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("disabled count", {16'h0, hwif_out.count}, 32'h0000_0010);
    cpuWrite(ADDR_COUNT, 32'h0000_1234, 32'h0000_00FF, "count low byte");
    checkOutput("count low byte", {16'h0, hwif_out.count}, 32'h0000_0034);

    $display("[TB] reset during transaction");
    applyStimulus(1'b1, 1'b1, ADDR_CTRL, 32'h0000_FF01, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset wr_ack", {31'h0, cpuif_wr_ack}, 32'h0);
    checkOutput("mid-reset hwif_out", {5'h0, hwif_out}, 32'h0040_0000);
    cpuRead(ADDR_CTRL, 32'h0000_1000, "mid-reset CTRL");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
